// File: rtl/pipe_control_unit_if.sv
// -----------------------------------------------------------------------------
// pipe_control_unit_if
// Bundles every signal between the pipelined control unit and the datapath /
// hazard unit, except clk and rst.
//
// Decode-stage inputs  : op, funct3, funct7
// Hazard inputs        : stall_D, flush_E
// Execute flag inputs  : Zero_E, Lt_E, Ltu_E
// Decode outputs       : ImmSrc_D, illegal_D
// Execute outputs      : ALUctrl_E, ALUsrcA_E, ALUsrcB_E, PCsrc_E, jalrmuxSel_E
// Memory outputs       : MemWrite_M, MemSize_M
// Writeback outputs    : RegWrite_W, ResultSrc_W
//
// The master modport is the datapath/hazard side that drives instruction
// fields and flags. The slave modport is the control unit itself.
// -----------------------------------------------------------------------------
interface pipe_control_unit_if #(
    parameter int ALUCTRL_WIDTH = 4
);
    logic [6:0]               op;
    logic [2:0]               funct3;
    logic                     funct7;
    logic                     stall_D;
    logic                     flush_E;
    logic                     Zero_E;
    logic                     Lt_E;
    logic                     Ltu_E;
    logic [2:0]               ImmSrc_D;
    logic                     illegal_D;
    logic [ALUCTRL_WIDTH-1:0] ALUctrl_E;
    logic                     ALUsrcA_E;
    logic                     ALUsrcB_E;
    logic                     PCsrc_E;
    logic                     jalrmuxSel_E;
    logic                     MemWrite_M;
    logic [2:0]               MemSize_M;
    logic                     RegWrite_W;
    logic [1:0]               ResultSrc_W;

    modport master (
        output op, funct3, funct7, stall_D, flush_E, Zero_E, Lt_E, Ltu_E,
        input  ImmSrc_D, illegal_D, ALUctrl_E, ALUsrcA_E, ALUsrcB_E, PCsrc_E,
               jalrmuxSel_E, MemWrite_M, MemSize_M, RegWrite_W, ResultSrc_W
    );

    modport slave (
        input  op, funct3, funct7, stall_D, flush_E, Zero_E, Lt_E, Ltu_E,
        output ImmSrc_D, illegal_D, ALUctrl_E, ALUsrcA_E, ALUsrcB_E, PCsrc_E,
               jalrmuxSel_E, MemWrite_M, MemSize_M, RegWrite_W, ResultSrc_W
    );
endinterface

// File: rtl/pipe_control_unit.sv
// -----------------------------------------------------------------------------
// pipe_control_unit
// Pipelined RV32I control unit. Decodes op/funct3/funct7 combinationally in
// Decode, then carries the control bundle through D->E, E->M and M->W
// registers. Branch and jump redirects are resolved in Execute from the ALU
// flags. Illegal encodings are flagged in Decode and never enable any write.
//
// Parameters
//   ALUCTRL_WIDTH  : ALU control code width, at least 4 (upper bits stay 0)
//   ILLEGAL_AS_NOP : 1 -> illegal instruction enters E as a bubble
//                    0 -> its decoded fields enter E with all enables cleared
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears all stages to bubbles
//   bus  : pipe_control_unit_if slave modport (decode fields, hazard
//          controls, ALU flags in; per-stage control signals out)
// -----------------------------------------------------------------------------
module pipe_control_unit #(
    parameter int ALUCTRL_WIDTH  = 4,
    parameter int ILLEGAL_AS_NOP = 1
) (
    input logic               clk,
    input logic               rst,
    pipe_control_unit_if.slave bus
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD   = ALUCTRL_WIDTH'(0);
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB   = ALUCTRL_WIDTH'(1);
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_AND   = ALUCTRL_WIDTH'(2);
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_OR    = ALUCTRL_WIDTH'(3);
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_XOR   = ALUCTRL_WIDTH'(4);
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLT   = ALUCTRL_WIDTH'(5);
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLTU  = ALUCTRL_WIDTH'(6);
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLL   = ALUCTRL_WIDTH'(7);
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_SRL   = ALUCTRL_WIDTH'(8);
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_SRA   = ALUCTRL_WIDTH'(9);
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_PASSB = ALUCTRL_WIDTH'(10);

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Full bundle carried into Execute; later stages keep only what they use.
    typedef struct packed {
        logic                     valid;
        logic                     reg_write;
        logic [1:0]               result_src;
        logic                     mem_write;
        logic [2:0]               mem_size;
        logic                     jump;
        logic                     branch;
        logic [2:0]               funct3;
        logic [ALUCTRL_WIDTH-1:0] alu_ctrl;
        logic                     alu_src_a;
        logic                     alu_src_b;
        logic                     jalr_sel;
    } e_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic [2:0] mem_size;
    } m_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } w_ctrl_t;

    localparam e_ctrl_t BUBBLE_E = '0;
    localparam m_ctrl_t BUBBLE_M = '0;
    localparam w_ctrl_t BUBBLE_W = '0;

    e_ctrl_t    dec;
    e_ctrl_t    to_e;
    logic [2:0] imm_src;
    logic       illegal;
    e_ctrl_t    e_q;
    m_ctrl_t    m_q;
    w_ctrl_t    w_q;
    logic       branch_cond;

    // Decode. Every case has a default that marks the encoding illegal, so an
    // unknown or X opcode/funct field can never reach an enable. Once illegal
    // is known, all enables and valid are cleared regardless of the path.
    always_comb begin
        dec           = BUBBLE_E;
        imm_src       = IMM_I;
        illegal       = 1'b0;
        dec.valid     = 1'b1;
        dec.funct3    = bus.funct3;
        case (bus.op)
            OP_R: begin
                dec.reg_write  = 1'b1;
                dec.result_src = RES_ALU;
                case ({bus.funct7, bus.funct3})
                    4'b0000: dec.alu_ctrl = ALU_ADD;
                    4'b1000: dec.alu_ctrl = ALU_SUB;
                    4'b0001: dec.alu_ctrl = ALU_SLL;
                    4'b0010: dec.alu_ctrl = ALU_SLT;
                    4'b0011: dec.alu_ctrl = ALU_SLTU;
                    4'b0100: dec.alu_ctrl = ALU_XOR;
                    4'b0101: dec.alu_ctrl = ALU_SRL;
                    4'b1101: dec.alu_ctrl = ALU_SRA;
                    4'b0110: dec.alu_ctrl = ALU_OR;
                    4'b0111: dec.alu_ctrl = ALU_AND;
                    default: illegal = 1'b1;
                endcase
            end
            OP_I: begin
                dec.reg_write  = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.result_src = RES_ALU;
                imm_src        = IMM_I;
                case (bus.funct3)
                    3'b000: dec.alu_ctrl = ALU_ADD;
                    3'b010: dec.alu_ctrl = ALU_SLT;
                    3'b011: dec.alu_ctrl = ALU_SLTU;
                    3'b100: dec.alu_ctrl = ALU_XOR;
                    3'b110: dec.alu_ctrl = ALU_OR;
                    3'b111: dec.alu_ctrl = ALU_AND;
                    3'b001: begin
                        case (bus.funct7)
                            1'b0:    dec.alu_ctrl = ALU_SLL;
                            default: illegal = 1'b1;
                        endcase
                    end
                    3'b101: begin
                        case (bus.funct7)
                            1'b0:    dec.alu_ctrl = ALU_SRL;
                            1'b1:    dec.alu_ctrl = ALU_SRA;
                            default: illegal = 1'b1;
                        endcase
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.alu_ctrl   = ALU_ADD;
                dec.result_src = RES_MEM;
                dec.mem_size   = bus.funct3;
                imm_src        = IMM_I;
                case (bus.funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ;
                    default: illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.alu_ctrl  = ALU_ADD;
                dec.mem_size  = bus.funct3;
                imm_src       = IMM_S;
                case (bus.funct3)
                    3'b000, 3'b001, 3'b010: ;
                    default: illegal = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALU_SUB;
                imm_src      = IMM_B;
                case (bus.funct3)
                    3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111: ;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LUI: begin
                dec.reg_write  = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.alu_ctrl   = ALU_PASSB;
                dec.result_src = RES_ALU;
                imm_src        = IMM_U;
            end
            OP_AUIPC: begin
                dec.reg_write  = 1'b1;
                dec.alu_src_a  = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.alu_ctrl   = ALU_ADD;
                dec.result_src = RES_ALU;
                imm_src        = IMM_U;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.alu_ctrl   = ALU_ADD;
                dec.result_src = RES_PC4;
                imm_src        = IMM_J;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.jalr_sel   = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.alu_ctrl   = ALU_ADD;
                dec.result_src = RES_PC4;
                imm_src        = IMM_I;
                case (bus.funct3)
                    3'b000:  ;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec.valid     = 1'b0;
            dec.reg_write = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
        end
    end

    // An illegal instruction either becomes a full bubble or keeps its
    // decoded datapath fields with the enables already cleared above.
    assign to_e = (illegal && (ILLEGAL_AS_NOP != 0)) ? BUBBLE_E : dec;

    // D->E register. flush_E wins over stall_D; both insert a bubble because
    // a stalled D instruction is re-presented and must not execute twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= BUBBLE_E;
        end else if (bus.flush_E) begin
            e_q <= BUBBLE_E;
        end else if (bus.stall_D) begin
            e_q <= BUBBLE_E;
        end else begin
            e_q <= to_e;
        end
    end

    // E->M and M->W registers always advance; there is no downstream stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q <= BUBBLE_M;
            w_q <= BUBBLE_W;
        end else begin
            m_q.reg_write  <= e_q.reg_write;
            m_q.result_src <= e_q.result_src;
            m_q.mem_write  <= e_q.mem_write;
            m_q.mem_size   <= e_q.mem_size;
            w_q.reg_write  <= m_q.reg_write;
            w_q.result_src <= m_q.result_src;
        end
    end

    // Branch condition from the funct3 held in E and the live ALU flags.
    always_comb begin
        branch_cond = 1'b0;
        case (e_q.funct3)
            3'b000:  branch_cond = bus.Zero_E;
            3'b001:  branch_cond = ~bus.Zero_E;
            3'b100:  branch_cond = bus.Lt_E;
            3'b101:  branch_cond = ~bus.Lt_E;
            3'b110:  branch_cond = bus.Ltu_E;
            3'b111:  branch_cond = ~bus.Ltu_E;
            default: branch_cond = 1'b0;
        endcase
    end

    // Redirect is the only combinational E output; it does not flush itself,
    // the hazard unit reacts to it with flush_E.
    assign bus.PCsrc_E = e_q.valid & (e_q.jump | (e_q.branch & branch_cond));

    assign bus.ImmSrc_D     = imm_src;
    assign bus.illegal_D    = illegal;
    assign bus.ALUctrl_E    = e_q.alu_ctrl;
    assign bus.ALUsrcA_E    = e_q.alu_src_a;
    assign bus.ALUsrcB_E    = e_q.alu_src_b;
    assign bus.jalrmuxSel_E = e_q.jalr_sel;
    assign bus.MemWrite_M   = m_q.mem_write;
    assign bus.MemSize_M    = m_q.mem_size;
    assign bus.RegWrite_W   = w_q.reg_write;
    assign bus.ResultSrc_W  = w_q.result_src;

endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
Pipelined successor to the single-cycle RV32I control unit. It decodes op/funct3/funct7 in the Decode (D) stage. Control bundles travel through internal D→E, E→M and M→W registers. Branch/jump redirects are resolved in Execute (E) using ALU flags. It covers the full RV32I integer subset, supports stall/flush from the hazard unit, and flags illegal encodings.

Parameters:
ALUCTRL_WIDTH, 4, width of the ALU control code; must be ≥4.
ILLEGAL_AS_NOP, 1, when 1 an illegal instruction enters E as a bubble; when 0 its decoded fields pass through with all enables forced 0.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
op  in  7  Instr[6:0] (D)
funct3  in  3  Instr[14:12] (D)
funct7  in  1  Instr[30] (D)
stall_D  in  1  hold D; insert bubble into E
flush_E  in  1  kill instruction entering E
Zero_E  in  1  ALU result == 0
Lt_E  in  1  signed rs1 < rs2
Ltu_E  in  1  unsigned rs1 < rs2
ImmSrc_D  out  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J
illegal_D  out  1  unsupported encoding in D
ALUctrl_E  out  ALUCTRL_WIDTH  ALU operation
ALUsrcA_E  out  1  0 rs1, 1 PC (auipc)
ALUsrcB_E  out  1  0 rs2, 1 imm
PCsrc_E  out  1  redirect taken
jalrmuxSel_E  out  1  target = rs1+imm (1) vs PC+imm (0)
MemWrite_M  out  1  store enable
MemSize_M  out  3  funct3 of load/store
RegWrite_W  out  1  register file write
ResultSrc_W  out  2  00 ALU, 01 mem, 10 PC+4

Behaviour:
- D decode is combinational. The E/M/W outputs come only from pipeline registers, except PCsrc_E.
- Latency: an instruction decoded in cycle n drives its E fields in n+1, M fields in n+2 and W fields in n+3.
- ALU codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 passB. Upper code bits are zero.
- R-type (0110011):
  - funct7=1 is legal only with funct3 000 (sub) or 101 (sra).
- I-ALU (0010011):
  - srai is funct3 101 with funct7=1.
  - slli with funct7=1 is illegal.
  - funct7 is ignored for the other funct3 values.
- Loads (0000011): funct3 ∈ {000,001,010,100,101}; add; ALUsrcB=1; ResultSrc=01; RegWrite=1.
- Stores (0100011): funct3 ∈ {000,001,010}; add; ALUsrcB=1; ImmSrc=001; MemWrite=1.
- Branches (1100011): ImmSrc=010; sub; no RegWrite.
  - Branch funct3 decodes as {000 beq:Zero, 001 bne:!Zero, 100 blt:Lt, 101 bge:!Lt, 110 bltu:Ltu, 111 bgeu:!Ltu}.
  - Branch funct3 010/011 is illegal.
- lui (0110111): ImmSrc=011, passB. auipc (0010111): ImmSrc=011, add, ALUsrcA=1. Both RegWrite=1, ResultSrc=00.
- jal (1101111): ImmSrc=100; RegWrite=1; ResultSrc=10; PCsrc unconditional in E.
- jalr (1100111, funct3 000 only): ImmSrc=000; jalrmuxSel=1; RegWrite=1; ResultSrc=10.
- Any other opcode is illegal: illegal_D=1, and the bubble rule applies.
- PCsrc_E = E_valid & (jump_E | (branch_E & cond(funct3_E, flags))).
- Bubble: RegWrite, MemWrite, branch, jump and valid all 0; other fields 0.
- Clock edge into E:
  - flush_E=1 loads a bubble, overriding stall_D.
  - Otherwise stall_D=1 loads a bubble.
  - Otherwise E loads the D decode.
- E→M and M→W always advance; no back-pressure downstream.
- PCsrc_E does not self-flush. The hazard unit asserts flush_E (and flushes D) on redirect. Simultaneous flush_E and a taken branch in E: the branch still redirects; the incoming instruction is killed.
- Reset (asynchronous, any time including mid-stream): all pipeline registers become bubbles. All E/M/W outputs are 0, PCsrc_E=0. The first instruction after rst deasserts appears in E on the next edge.
- X/unknown inputs never propagate into enables: a default case yields illegal.

Test Plan:
- Reset mid-stream: assert rst while a sw is in M → MemWrite_M=0 and RegWrite_W=0 immediately, without waiting for a clock edge.
- add→lw→sw back-to-back, no stalls:
  - add: RegWrite_W=1, ResultSrc_W=00 at cycle 3.
  - lw: ResultSrc_W=01, MemSize_M=010.
  - sw: MemWrite_M=1 at cycle 4, RegWrite_W=0.
- Branch sweep, all six branch funct3 in E:
  - beq Zero=1 → PCsrc_E=1; bne Zero=1 → 0.
  - blt Lt=1 → 1; bgeu Ltu=1 → 0.
  - funct3 011 → illegal_D=1 and PCsrc never asserts.
- Stall then flush: stall_D=1 for 2 cycles with an addi in D → 2 bubbles in E (RegWrite_E path 0), then addi enters. Asserting flush_E together with stall_D yields a bubble.
- jal/jalr:
  - jal: PCsrc_E=1 regardless of flags; ResultSrc_W=10; RegWrite_W=1.
  - jalr: jalrmuxSel_E=1.
  - jalr with funct3=001 → illegal, bubble.
- R/I edge cases:
  - sub (funct7=1, funct3=000) → ALUctrl_E=0001.
  - srai → 1001.
  - slli with funct7=1 → illegal_D=1.
  - auipc → ALUsrcA_E=1, ALUctrl_E=0000.
  - lui → 1010.
